flash_prog_seq: RTL and testbench

- Autonomous JEDEC command sequencer for the 512 KB parallel boot flash (Am29F040-class, 8-bit bus).
- Sits between the AVR-SPI register file, which supplies the opcode, address and data plus a one-cycle start strobe, and the ROM pins.
- The ROM pins are csrom, romoe_n, romwe_n, a[13:0], rompg0_n/dos_n/rompg2..4, and d.
- Lets the AVR issue single read/program/erase commands instead of bit-banging FLASH_CTRL.

---
 rtl/flash_prog_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_flash_prog_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_prog_seq.sv
// flash_prog_seq: autonomous JEDEC command sequencer for an 8-bit Am29F040-class boot flash.
// Accepts a single READ / PROGRAM / SECTOR_ERASE / CHIP_ERASE command on a one-cycle start
// strobe, then drives the unlock write list and DQ6/DQ5 status polling on its own.
//
// Ports
//   fclk, rst_n           clock, asynchronous active-low reset
//   start, op, addr,      command strobe and operands (sampled only when idle)
//   wdata
//   busy, done, err       status; done/err are one-cycle pulses in the cycle busy falls
//   rdata                 READ result or last polled status byte
//   fl_a, fl_dout,        flash address / write data / data-bus drive enable
//   fl_doe
//   fl_din                flash data as seen by the FPGA
//   fl_cs, fl_oe, fl_we   active-high chip select, output enable, write enable
module flash_prog_seq #(
    parameter int unsigned WE_CYC = 4,
    parameter int unsigned SU_CYC = 1,
    parameter int unsigned TMO_W  = 26
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [18:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [18:0] fl_a,
    output logic [7:0]  fl_dout,
    output logic        fl_doe,
    input  logic [7:0]  fl_din,
    output logic        fl_cs,
    output logic        fl_oe,
    output logic        fl_we
);

    localparam logic [1:0] OpRead   = 2'd0;
    localparam logic [1:0] OpProg   = 2'd1;
    localparam logic [1:0] OpSecEr  = 2'd2;

    localparam int unsigned CntMax = (WE_CYC > SU_CYC) ? WE_CYC : SU_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle,
        StWSu,
        StWPul,
        StWHld,
        StRSu,
        StRPul,
        StRHld,
        StPChk,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cyc_q, cyc_d;
    logic [2:0]        step_q, step_d;
    logic [1:0]        op_q, op_d;
    logic [18:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [18:0]       fl_a_q, fl_a_d;
    logic [7:0]        fl_dout_q, fl_dout_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              prev6_q, prev6_d;
    logic [TMO_W-1:0]  poll_q, poll_d;
    logic              prime_q, prime_d;
    logic              recheck_q, recheck_d;
    logic              fail_q, fail_d;

    logic              su_end, we_end;
    logic [2:0]        last_step, nxt_step;
    logic [18:0]       sector_a, poll_a;
    logic [18:0]       wr_a;
    logic [7:0]        wr_d;
    logic              tog, tmo;

    assign su_end    = (cyc_q == CntW'(SU_CYC - 1));
    assign we_end    = (cyc_q == CntW'(WE_CYC - 1));
    assign last_step = (op_q == OpProg) ? 3'd3 : 3'd5;
    assign nxt_step  = step_q + 3'd1;
    assign sector_a  = {addr_q[18:16], 16'h0000};
    assign poll_a    = (op_q == OpProg) ? addr_q : sector_a;
    assign tog       = rdata_q[6] ^ prev6_q;
    assign tmo       = (poll_q == {TMO_W{1'b1}});

    // Address/data of the write that follows the current one (entry 0 is loaded on start).
    always_comb begin
        wr_a = 19'h00555;
        wr_d = 8'hAA;
        case (nxt_step)
            3'd1: begin
                wr_a = 19'h002AA;
                wr_d = 8'h55;
            end
            3'd2: wr_d = (op_q == OpProg) ? 8'hA0 : 8'h80;
            3'd3: begin
                if (op_q == OpProg) begin
                    wr_a = addr_q;
                    wr_d = wdata_q;
                end
            end
            3'd4: begin
                wr_a = 19'h002AA;
                wr_d = 8'h55;
            end
            3'd5: begin
                if (op_q == OpSecEr) begin
                    wr_a = sector_a;
                    wr_d = 8'h30;
                end else begin
                    wr_d = 8'h10;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        step_d    = step_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fl_a_d    = fl_a_q;
        fl_dout_d = fl_dout_q;
        rdata_d   = rdata_q;
        prev6_d   = prev6_q;
        poll_d    = poll_q;
        prime_d   = prime_q;
        recheck_d = recheck_q;
        fail_d    = fail_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    cyc_d     = '0;
                    step_d    = '0;
                    poll_d    = '0;
                    prime_d   = 1'b1;
                    recheck_d = 1'b0;
                    fail_d    = 1'b0;
                    if (op == OpRead) begin
                        fl_a_d  = addr;
                        state_d = StRSu;
                    end else begin
                        // Every write list opens with 555/AA.
                        fl_a_d    = 19'h00555;
                        fl_dout_d = 8'hAA;
                        state_d   = StWSu;
                    end
                end
            end
            StWSu: begin
                cyc_d = cyc_q + CntW'(1);
                if (su_end) begin
                    cyc_d   = '0;
                    state_d = StWPul;
                end
            end
            StWPul: begin
                cyc_d = cyc_q + CntW'(1);
                if (we_end) begin
                    cyc_d   = '0;
                    state_d = StWHld;
                end
            end
            StWHld: begin
                cyc_d = cyc_q + CntW'(1);
                if (su_end) begin
                    cyc_d = '0;
                    if (step_q == last_step) begin
                        fl_a_d  = poll_a;
                        state_d = StRSu;
                    end else begin
                        step_d    = nxt_step;
                        fl_a_d    = wr_a;
                        fl_dout_d = wr_d;
                        state_d   = StWSu;
                    end
                end
            end
            StRSu: begin
                cyc_d = cyc_q + CntW'(1);
                if (su_end) begin
                    cyc_d   = '0;
                    state_d = StRPul;
                end
            end
            StRPul: begin
                cyc_d = cyc_q + CntW'(1);
                if (we_end) begin
                    cyc_d   = '0;
                    rdata_d = fl_din;
                    prev6_d = rdata_q[6];
                    if (op_q != OpRead) begin
                        poll_d = poll_q + TMO_W'(1);
                    end
                    state_d = StRHld;
                end
            end
            StRHld: begin
                cyc_d = cyc_q + CntW'(1);
                if (su_end) begin
                    cyc_d = '0;
                    if (op_q == OpRead) begin
                        state_d = StPChk;
                    end else if (!prime_q && !tog) begin
                        state_d = StPChk;
                    end else if (!prime_q && recheck_q) begin
                        // DQ6 still toggling on the confirmation pair: the operation failed.
                        fail_d  = 1'b1;
                        state_d = StPChk;
                    end else begin
                        // DQ5 set while toggling: re-arm so the next two reads form a fresh pair.
                        if (!prime_q && rdata_q[5]) begin
                            recheck_d = 1'b1;
                            prime_d   = 1'b1;
                        end else begin
                            prime_d = 1'b0;
                        end
                        if (tmo) begin
                            fail_d  = 1'b1;
                            state_d = StPChk;
                        end else begin
                            state_d = StRSu;
                        end
                    end
                end
            end
            StPChk: state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            step_q    <= '0;
            op_q      <= OpRead;
            addr_q    <= '0;
            wdata_q   <= '0;
            fl_a_q    <= '0;
            fl_dout_q <= '0;
            rdata_q   <= 8'hFF;
            prev6_q   <= 1'b0;
            poll_q    <= '0;
            prime_q   <= 1'b0;
            recheck_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            step_q    <= step_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fl_a_q    <= fl_a_d;
            fl_dout_q <= fl_dout_d;
            rdata_q   <= rdata_d;
            prev6_q   <= prev6_d;
            poll_q    <= poll_d;
            prime_q   <= prime_d;
            recheck_q <= recheck_d;
            fail_q    <= fail_d;
        end
    end

    // Strobes decode straight from the state register, so reset drops them at once.
    assign busy    = (state_q != StIdle) && (state_q != StFin);
    assign fl_cs   = busy;
    assign fl_doe  = (state_q == StWSu) || (state_q == StWPul) || (state_q == StWHld);
    assign fl_we   = (state_q == StWPul);
    assign fl_oe   = (state_q == StRPul);
    assign done    = (state_q == StFin) && !fail_q;
    assign err     = (state_q == StFin) && fail_q;
    assign rdata   = rdata_q;
    assign fl_a    = fl_a_q;
    assign fl_dout = fl_dout_q;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Directed bench for flash_prog_seq with a small behavioural flash status model.
module tb_flash_prog_seq;

    logic        fclk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic        busy, done, err;
    logic [7:0]  rdata;
    logic [18:0] fl_a;
    logic [7:0]  fl_dout;
    logic        fl_doe;
    logic [7:0]  fl_din;
    logic        fl_cs, fl_oe, fl_we;

    always #5 fclk = ~fclk;

    flash_prog_seq #(
        .WE_CYC(4),
        .SU_CYC(1),
        .TMO_W (4)
    ) dut (
        .fclk   (fclk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .fl_a   (fl_a),
        .fl_dout(fl_dout),
        .fl_doe (fl_doe),
        .fl_din (fl_din),
        .fl_cs  (fl_cs),
        .fl_oe  (fl_oe),
        .fl_we  (fl_we)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Bus log and model state for the current command.
    logic [18:0] wa [0:7];
    logic [7:0]  wd [0:7];
    int nw, nr, wlen, olen, bad_wlen, bad_olen, bad_ra, both_on, cyc, t0, t1;
    logic we_prev, oe_prev, busy_prev, fin, fin_err, err_seen, doe_seen, end_busy, end_cs;
    int m_tn;
    logic m_dq5, m_const;
    logic [7:0] m_cval;
    logic [18:0] m_pa;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        nw = 0; nr = 0; wlen = 0; olen = 0; bad_wlen = 0; bad_olen = 0; bad_ra = 0;
        both_on = 0; cyc = 0; t0 = -1; t1 = -1;
        we_prev = 1'b0; oe_prev = 1'b0; busy_prev = 1'b0;
        fin = 1'b0; fin_err = 1'b0; err_seen = 1'b0; doe_seen = 1'b0;
        end_busy = 1'b1; end_cs = 1'b1;
    endtask

    // Called once per cycle at the falling edge.
    task automatic mon();
        logic b6;
        cyc++;
        if (fl_oe && fl_doe) both_on++;
        if (fl_doe) doe_seen = 1'b1;
        if (fl_we && !we_prev) begin
            if (nw < 8) begin
                wa[nw] = fl_a;
                wd[nw] = fl_dout;
            end
            nw++;
            wlen = 0;
        end
        if (fl_we) wlen++;
        if (!fl_we && we_prev && wlen != 4) bad_wlen++;
        if (fl_oe && !oe_prev) begin
            nr++;
            olen = 0;
            if (fl_a != m_pa) bad_ra++;
            if (m_const) begin
                fl_din = m_cval;
            end else begin
                b6 = (nr <= m_tn) ? nr[0] : m_tn[0];
                fl_din = {1'b0, b6, m_dq5, 5'b00000};
            end
        end
        if (fl_oe) olen++;
        if (!fl_oe && oe_prev && olen != 4) bad_olen++;
        if (busy && !busy_prev) t0 = cyc;
        if (err) err_seen = 1'b1;
        if ((done || err) && !fin) begin
            fin = 1'b1;
            fin_err = err;
            t1 = cyc;
            end_busy = busy;
            end_cs = fl_cs;
        end
        we_prev = fl_we;
        oe_prev = fl_oe;
        busy_prev = busy;
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] o, input logic [18:0] a,
                           input logic [7:0] d, input int tn, input logic dq5,
                           input logic cmode, input logic [7:0] cval, input logic [18:0] pa,
                           input int restart_at);
        clr_log();
        m_tn = tn; m_dq5 = dq5; m_const = cmode; m_cval = cval; m_pa = pa;
        @(negedge fclk);
        op = o; addr = a; wdata = d; start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        mon();
        for (int i = 0; i < 400; i++) begin
            @(negedge fclk);
            start = (i == restart_at);
            if (start) begin
                op = 2'd0; addr = 19'h12345; wdata = 8'hEE;
            end
            mon();
            if (fin) break;
        end
        start = 1'b0;
        check({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; addr = '0; wdata = '0; fl_din = 8'hFF;
        clr_log();
        m_tn = 0; m_dq5 = 1'b0; m_const = 1'b1; m_cval = 8'h00; m_pa = '0;
        repeat (3) @(negedge fclk);
        check("rst_status", {29'd0, busy, done, err}, 32'd0);
        check("rst_rdata", 32'(rdata), 32'hFF);
        check("rst_fl_a", 32'(fl_a), 32'd0);
        check("rst_fl_dout", 32'(fl_dout), 32'd0);
        check("rst_ctrl", {28'd0, fl_cs, fl_oe, fl_we, fl_doe}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge fclk);

        // READ
        run_cmd("read", 2'd0, 19'h12345, 8'h00, 0, 1'b0, 1'b1, 8'h5A, 19'h12345, -1);
        check("read_nr", 32'(nr), 32'd1);
        check("read_nw", 32'(nw), 32'd0);
        check("read_oe_len", 32'(bad_olen), 32'd0);
        check("read_doe", 32'(doe_seen), 32'd0);
        check("read_rdata", 32'(rdata), 32'h5A);
        check("read_lat", 32'(t1 - t0), 32'd7);
        check("read_err", 32'(err_seen), 32'd0);
        check("read_bad_ra", 32'(bad_ra), 32'd0);

        // PROGRAM, DQ6 toggles over 3 reads
        run_cmd("prog", 2'd1, 19'h7FFFF, 8'hC3, 3, 1'b0, 1'b0, 8'h00, 19'h7FFFF, -1);
        check("prog_nw", 32'(nw), 32'd4);
        check("prog_w0", {5'd0, wa[0], wd[0]}, {5'd0, 19'h00555, 8'hAA});
        check("prog_w1", {5'd0, wa[1], wd[1]}, {5'd0, 19'h002AA, 8'h55});
        check("prog_w2", {5'd0, wa[2], wd[2]}, {5'd0, 19'h00555, 8'hA0});
        check("prog_w3", {5'd0, wa[3], wd[3]}, {5'd0, 19'h7FFFF, 8'hC3});
        check("prog_we_len", 32'(bad_wlen), 32'd0);
        check("prog_nr", 32'(nr), 32'd4);
        check("prog_poll_a", 32'(bad_ra), 32'd0);
        check("prog_result", 32'(fin_err), 32'd0);
        check("prog_lat", 32'(t1 - t0), 32'd49);
        check("prog_rdata", 32'(rdata), 32'h40);
        check("prog_oe_doe", 32'(both_on), 32'd0);

        // SECTOR_ERASE
        run_cmd("serase", 2'd2, 19'h2ABCD, 8'h00, 1, 1'b0, 1'b0, 8'h00, 19'h20000, -1);
        check("serase_nw", 32'(nw), 32'd6);
        check("serase_w2", {5'd0, wa[2], wd[2]}, {5'd0, 19'h00555, 8'h80});
        check("serase_w5", {5'd0, wa[5], wd[5]}, {5'd0, 19'h20000, 8'h30});
        check("serase_poll_a", 32'(bad_ra), 32'd0);
        check("serase_nr", 32'(nr), 32'd2);
        check("serase_result", 32'(fin_err), 32'd0);
        check("serase_lat", 32'(t1 - t0), 32'd49);

        // CHIP_ERASE, plus a start landing in the FIN cycle
        run_cmd("cerase", 2'd3, 19'h51234, 8'h00, 1, 1'b0, 1'b0, 8'h00, 19'h50000, -1);
        check("cerase_w3", {5'd0, wa[3], wd[3]}, {5'd0, 19'h00555, 8'hAA});
        check("cerase_w5", {5'd0, wa[5], wd[5]}, {5'd0, 19'h00555, 8'h10});
        check("cerase_result", 32'(fin_err), 32'd0);
        op = 2'd0; addr = 19'h00001; start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        check("fin_start_idle", 32'(busy), 32'd0);
        @(negedge fclk);
        check("fin_start_idle2", {30'd0, busy, fl_cs}, 32'd0);

        // DQ5 failure with DQ6 toggling through the recheck pair
        run_cmd("dq5f", 2'd1, 19'h00100, 8'h11, 1000, 1'b1, 1'b0, 8'h00, 19'h00100, -1);
        check("dq5f_err", 32'(fin_err), 32'd1);
        check("dq5f_end_busy", {30'd0, end_busy, end_cs}, 32'd0);
        check("dq5f_nr", 32'(nr), 32'd4);
        check("dq5f_lat", 32'(t1 - t0), 32'd49);
        check("dq5f_rdata", 32'(rdata), 32'h20);

        // DQ5 set but toggling stops on the recheck pair
        run_cmd("dq5ok", 2'd1, 19'h00100, 8'h11, 3, 1'b1, 1'b0, 8'h00, 19'h00100, -1);
        check("dq5ok_result", {31'd0, fin_err}, 32'd0);
        check("dq5ok_nr", 32'(nr), 32'd4);

        // Timeout: TMO_W=4 gives 15 poll reads
        run_cmd("tmo", 2'd1, 19'h04444, 8'h77, 1000, 1'b0, 1'b0, 8'h00, 19'h04444, -1);
        check("tmo_err", 32'(fin_err), 32'd1);
        check("tmo_nr", 32'(nr), 32'd15);
        check("tmo_lat", 32'(t1 - t0), 32'd115);

        // start while busy must not disturb the running program
        run_cmd("restart", 2'd1, 19'h30F0F, 8'h5A, 3, 1'b0, 1'b0, 8'h00, 19'h30F0F, 10);
        check("restart_nw", 32'(nw), 32'd4);
        check("restart_w3", {5'd0, wa[3], wd[3]}, {5'd0, 19'h30F0F, 8'h5A});
        check("restart_nr", 32'(nr), 32'd4);
        check("restart_lat", 32'(t1 - t0), 32'd49);

        // Reset during a WE pulse
        @(negedge fclk);
        op = 2'd1; addr = 19'h00200; wdata = 8'h99; start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (fl_we) break;
            @(negedge fclk);
        end
        check("rst_mid_in_wpul", 32'(fl_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(fl_we), 32'd0);
        check("rst_mid_busy", {29'd0, busy, done, err}, 32'd0);
        check("rst_mid_cs", {30'd0, fl_cs, fl_doe}, 32'd0);
        @(negedge fclk);
        rst_n = 1'b1;
        repeat (3) @(negedge fclk);
        check("rst_after_idle", 32'(busy), 32'd0);

        run_cmd("read2", 2'd0, 19'h00042, 8'h00, 0, 1'b0, 1'b1, 8'hA5, 19'h00042, -1);
        check("read2_rdata", 32'(rdata), 32'hA5);
        check("read2_lat", 32'(t1 - t0), 32'd7);
        check("read2_result", 32'(fin_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
